// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS decode-stage register file.
//   DATA_W_DEF     : default register width in bits
//   ADDR_W_DEF     : default register address width (depth = 2**ADDR_W)
//   REG_ZERO       : index of the hardwired-zero register
//   MAX_READ_PORTS : upper limit on the number of read ports
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 5;
    localparam int REG_ZERO       = 0;
    localparam int MAX_READ_PORTS = 4;

endpackage

// File: rtl/mips_rf_read_port.sv
// -----------------------------------------------------------------------------
// mips_rf_read_port
// One combinational read port: selects a register by address. Register 0
// always reads as zero. When MIPS_RF_BYPASS_EN is defined, a write that is
// being accepted this cycle to the same address is forwarded to the output,
// with write port 1 taking priority over write port 0.
//
// Ports:
//   addr        : read address
//   regs        : register storage array (all entries)
//   data        : read data
//   byp_valid_k : write port k accepted this cycle (MIPS_RF_BYPASS_EN only)
//   byp_reg_k   : write port k address            (MIPS_RF_BYPASS_EN only)
//   byp_data_k  : write port k data               (MIPS_RF_BYPASS_EN only)
// -----------------------------------------------------------------------------
module mips_rf_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    output logic [DATA_W-1:0] data
`ifdef MIPS_RF_BYPASS_EN
   ,input  logic              byp_valid_0,
    input  logic [ADDR_W-1:0] byp_reg_0,
    input  logic [DATA_W-1:0] byp_data_0,
    input  logic              byp_valid_1,
    input  logic [ADDR_W-1:0] byp_reg_1,
    input  logic [DATA_W-1:0] byp_data_1
`endif
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    always_comb begin
        // NOTE: default assignment first so every path drives data and no latch is inferred.
        data = regs[addr];
`ifdef MIPS_RF_BYPASS_EN
        if (byp_valid_1 && (byp_reg_1 == addr)) begin
            data = byp_data_1;
        end else if (byp_valid_0 && (byp_reg_0 == addr)) begin
            data = byp_data_0;
        end
`endif
        // Zero register wins over everything, including forwarded data.
        if (addr == ZERO_ADDR) begin
            data = '0;
        end
    end

endmodule

// File: rtl/mips_regfile_mp.sv
// -----------------------------------------------------------------------------
// mips_regfile_mp
// Multi-port MIPS register file: NUM_READ combinational read ports, two write
// ports (port 1 wins on address collision), hardwired-zero register 0 and a
// per-register dirty bitmap. Optional write-to-read forwarding is enabled by
// defining the macro MIPS_RF_BYPASS_EN.
//
// Ports:
//   clk                : clock, state updates on rising edge
//   rst_n              : asynchronous active-low reset
//   read_reg           : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   read_data          : packed read data, port i at [i*DATA_W +: DATA_W]
//   write_reg_0/1      : write addresses
//   write_data_0/1     : write data
//   signal_reg_write_0/1 : write enables
//   clear_dirty        : synchronous clear of the dirty bitmap
//   dirty              : bit r set when register r written since last clear
// -----------------------------------------------------------------------------
module mips_regfile_mp
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_READ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_READ*ADDR_W-1:0] read_reg,
    output logic [NUM_READ*DATA_W-1:0] read_data,
    input  logic [ADDR_W-1:0]          write_reg_0,
    input  logic [ADDR_W-1:0]          write_reg_1,
    input  logic [DATA_W-1:0]          write_data_0,
    input  logic [DATA_W-1:0]          write_data_1,
    input  logic                       signal_reg_write_0,
    input  logic                       signal_reg_write_1,
    input  logic                       clear_dirty,
    output logic [2**ADDR_W-1:0]       dirty
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    if (NUM_READ < 1 || NUM_READ > MAX_READ_PORTS) begin : g_bad_cfg
        $error("mips_regfile_mp: NUM_READ out of range");
    end

    logic [DATA_W-1:0] regs [DEPTH];
    logic              accept_0;
    logic              accept_1;
    logic [DEPTH-1:0]  set_mask;

    // A write is accepted only when enabled and not aimed at register 0.
    assign accept_0 = signal_reg_write_0 && (write_reg_0 != ZERO_ADDR);
    assign accept_1 = signal_reg_write_1 && (write_reg_1 != ZERO_ADDR);

    // NOTE: the storage array is reset explicitly because reads must return 0
    // immediately on reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments; on a collision the later
            // statement (port 1) is the one that takes effect.
            if (accept_0) begin
                regs[write_reg_0] <= write_data_0;
            end
            if (accept_1) begin
                regs[write_reg_1] <= write_data_1;
            end
        end
    end

    // Registers touched by an accepted write this cycle.
    always_comb begin
        set_mask = '0;
        if (accept_0) begin
            set_mask[write_reg_0] = 1'b1;
        end
        if (accept_1) begin
            set_mask[write_reg_1] = 1'b1;
        end
    end

    // Clear first, then set, so a write in the clearing cycle still marks dirty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty <= '0;
        end else begin
            dirty <= (clear_dirty ? '0 : dirty) | set_mask;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        mips_rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_read_port (
            .addr        (read_reg[i*ADDR_W +: ADDR_W]),
            .regs        (regs),
            .data        (read_data[i*DATA_W +: DATA_W])
`ifdef MIPS_RF_BYPASS_EN
            // Forwarding is suppressed while reset is asserted.
           ,.byp_valid_0 (accept_0 && rst_n),
            .byp_reg_0   (write_reg_0),
            .byp_data_0  (write_data_0),
            .byp_valid_1 (accept_1 && rst_n),
            .byp_reg_1   (write_reg_1),
            .byp_data_1  (write_data_1)
`endif
        );
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_mips_regfile_mp
// Self-checking bench for mips_regfile_mp. A behavioural model (array of
// register values plus a dirty bit vector) is updated once per rising edge
// from the driven write requests and predicts read_data and dirty.
// Honours MIPS_RF_BYPASS_EN for the same-cycle read expectation.
// -----------------------------------------------------------------------------
module tb_mips_regfile_mp;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_READ = 3;
    localparam int DEPTH    = 2**ADDR_W;
`ifdef MIPS_RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                       clk;
    logic                       rst_n;
    logic [NUM_READ*ADDR_W-1:0] read_reg;
    logic [NUM_READ*DATA_W-1:0] read_data;
    logic [ADDR_W-1:0]          write_reg_0;
    logic [ADDR_W-1:0]          write_reg_1;
    logic [DATA_W-1:0]          write_data_0;
    logic [DATA_W-1:0]          write_data_1;
    logic                       signal_reg_write_0;
    logic                       signal_reg_write_1;
    logic                       clear_dirty;
    logic [DEPTH-1:0]           dirty;

    int compared   = 0;
    int mismatched = 0;

    logic [DATA_W-1:0] mdl_regs [DEPTH];
    logic [DEPTH-1:0]  mdl_dirty;

    mips_regfile_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_READ (NUM_READ)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .read_reg           (read_reg),
        .read_data          (read_data),
        .write_reg_0        (write_reg_0),
        .write_reg_1        (write_reg_1),
        .write_data_0       (write_data_0),
        .write_data_1       (write_data_1),
        .signal_reg_write_0 (signal_reg_write_0),
        .signal_reg_write_1 (signal_reg_write_1),
        .clear_dirty        (clear_dirty),
        .dirty              (dirty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int r = 0; r < DEPTH; r++) mdl_regs[r] = '0;
        mdl_dirty = '0;
    endfunction

    // Applies one rising edge: port 0 then port 1, so port 1 overrides.
    function automatic void model_edge();
        if (clear_dirty) mdl_dirty = '0;
        if (signal_reg_write_0 && write_reg_0 != 0) begin
            mdl_regs[write_reg_0]  = write_data_0;
            mdl_dirty[write_reg_0] = 1'b1;
        end
        if (signal_reg_write_1 && write_reg_1 != 0) begin
            mdl_regs[write_reg_1]  = write_data_1;
            mdl_dirty[write_reg_1] = 1'b1;
        end
    endfunction

    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (BYPASS && rst_n) begin
            if (signal_reg_write_1 && write_reg_1 == a) return write_data_1;
            if (signal_reg_write_0 && write_reg_0 == a) return write_data_0;
        end
        return mdl_regs[a];
    endfunction

    function automatic logic [NUM_READ*DATA_W-1:0] exp_read_vec();
        logic [NUM_READ*DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_READ; i++)
            v[i*DATA_W +: DATA_W] = exp_read(read_reg[i*ADDR_W +: ADDR_W]);
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_reads(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                             input logic [ADDR_W-1:0] a2);
        read_reg = {a2, a1, a0};
    endtask

    task automatic drive_write(input logic e0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                               input logic e1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        signal_reg_write_0 = e0; write_reg_0 = a0; write_data_0 = d0;
        signal_reg_write_1 = e1; write_reg_1 = a1; write_data_1 = d1;
    endtask

    task automatic idle();
        drive_write(1'b0, '0, '0, 1'b0, '0, '0);
        clear_dirty = 1'b0;
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        set_reads(5'd5, 5'd5, 5'd0);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compared++;
        if (read_data !== exp_read_vec()) begin
            mismatched++;
            $display("FAIL reset_read: got %h expected %h", read_data, exp_read_vec());
        end
        compared++;
        if (dirty !== '0) begin
            mismatched++;
            $display("FAIL reset_dirty: got %h expected 0", dirty);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Write r5, then assert reset mid-cycle.
        drive_write(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        cycle();
        idle();
        #1;
        compared++;
        if (read_data[DATA_W-1:0] !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL prereset_r5: got %h expected deadbeef", read_data[DATA_W-1:0]);
        end
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        compared++;
        if (read_data !== exp_read_vec()) begin
            mismatched++;
            $display("FAIL midcycle_reset_read: got %h expected %h", read_data, exp_read_vec());
        end
        compared++;
        if (dirty !== mdl_dirty) begin
            mismatched++;
            $display("FAIL midcycle_reset_dirty: got %h expected %h", dirty, mdl_dirty);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        set_reads(5'd2, 5'd2, 5'd2);
        drive_write(1'b1, 5'd2, 32'h2A, 1'b0, '0, '0);
        cycle();
        idle();
        #1;
        compared++;
        if (read_data !== {3{32'h2A}} || read_data !== exp_read_vec()) begin
            mismatched++;
            $display("FAIL basic_read: got %h expected %h", read_data, exp_read_vec());
        end
        compared++;
        if (dirty !== mdl_dirty || dirty[2] !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_dirty: got %h expected %h", dirty, mdl_dirty);
        end
    endtask

    task automatic test_collision();
        set_reads(5'd7, 5'd2, 5'd7);
        drive_write(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
        cycle();
        idle();
        #1;
        compared++;
        if (read_data[DATA_W-1:0] !== 32'h22 || read_data !== exp_read_vec()) begin
            mismatched++;
            $display("FAIL collision_read: got %h expected %h", read_data, exp_read_vec());
        end
        compared++;
        if (dirty !== mdl_dirty) begin
            mismatched++;
            $display("FAIL collision_dirty: got %h expected %h", dirty, mdl_dirty);
        end
    endtask

    task automatic test_zero_reg();
        set_reads(5'd0, 5'd0, 5'd0);
        drive_write(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        compared++;
        if (read_data !== '0) begin
            mismatched++;
            $display("FAIL zero_same_cycle: got %h expected 0", read_data);
        end
        cycle();
        idle();
        #1;
        compared++;
        if (read_data !== '0) begin
            mismatched++;
            $display("FAIL zero_after_edge: got %h expected 0", read_data);
        end
        compared++;
        if (dirty[0] !== 1'b0 || dirty !== mdl_dirty) begin
            mismatched++;
            $display("FAIL zero_dirty: got %h expected %h", dirty, mdl_dirty);
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp_now;
        set_reads(5'd3, 5'd3, 5'd3);
        drive_write(1'b1, 5'd3, 32'h15, 1'b0, '0, '0);
        exp_now = BYPASS ? 32'h15 : mdl_regs[3];
        #1;
        compared++;
        if (read_data !== {3{exp_now}}) begin
            mismatched++;
            $display("FAIL bypass_same_cycle: got %h expected %h", read_data, {3{exp_now}});
        end
        cycle();
        idle();
        #1;
        compared++;
        if (read_data !== {3{32'h15}}) begin
            mismatched++;
            $display("FAIL bypass_after_edge: got %h expected %h", read_data, {3{32'h15}});
        end
    endtask

    task automatic test_dirty_clear();
        drive_write(1'b1, 5'd9, 32'h99, 1'b0, '0, '0);
        cycle();
        drive_write(1'b1, 5'd4, 32'h44, 1'b0, '0, '0);
        clear_dirty = 1'b1;
        cycle();
        idle();
        #1;
        compared++;
        if (dirty[4] !== 1'b1 || dirty[9] !== 1'b0 || dirty !== mdl_dirty) begin
            mismatched++;
            $display("FAIL dirty_clear: got %h expected %h", dirty, mdl_dirty);
        end
        clear_dirty = 1'b1;
        cycle();
        idle();
        #1;
        compared++;
        if (dirty !== '0) begin
            mismatched++;
            $display("FAIL dirty_clear_only: got %h expected 0", dirty);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            // Small address range makes collisions and read-after-write common.
            drive_write(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom(),
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom());
            clear_dirty = ($urandom_range(0, 7) == 0);
            set_reads(5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)), 5'($urandom()));
            #1;
            compared++;
            if (read_data !== exp_read_vec()) begin
                mismatched++;
                $display("FAIL random_read[%0d]: got %h expected %h", n, read_data, exp_read_vec());
            end
            cycle();
            compared++;
            if (dirty !== mdl_dirty) begin
                mismatched++;
                $display("FAIL random_dirty[%0d]: got %h expected %h", n, dirty, mdl_dirty);
            end
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        read_reg = '0;
        model_reset();
        test_reset();
        test_basic();
        test_collision();
        test_zero_reg();
        test_bypass();
        test_dirty_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
